// File: rtl/char_pair_feeder.sv
// char_pair_feeder: buffers host character pairs in a FIFO and presents one
// registered pair at a time to the traversal engine, advancing on each
// input_char_flag pulse. Tracks end-of-stream via the in_last marker.
// Optional feature macro: FEEDER_STALL_CNT_EN adds the stall_count output.
module char_pair_feeder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int STALL_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_char,
  input  logic [7:0]         in_char_2,
  input  logic               in_last,
  input  logic               input_char_flag,
  output logic [7:0]         input_char,
  output logic [7:0]         input_char_2,
  output logic               char_valid,
  output logic               stream_done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] stall_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  logic [16:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                full;
  logic                empty;
  logic                wr_en;
  logic                pop;
  logic                last_acc;
  logic                p_last;
  logic [16:0]         head;
  state_t              state;

  // Extra pointer MSB separates a full buffer from an empty one.
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  // Once the final pair is in, nothing further enters until reset.
  assign wr_en = in_valid && in_ready && !last_acc;
  assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Decide whether the head of the FIFO moves into the presentation register.
  always_comb begin
    pop = 1'b0;
    case (state)
      S_EMPTY: pop = !empty && !stream_done;
      S_FULL:  pop = input_char_flag && !p_last && !empty;
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage; contents are don't-care after reset since pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {in_last, in_char_2, in_char};
  end

  // Write pointer and end-of-input tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      last_acc <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
      if (in_last) last_acc <= 1'b1;
    end
  end

  // Presentation FSM: owns the read pointer and the registered output pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_EMPTY;
      rd_ptr       <= '0;
      input_char   <= 8'h00;
      input_char_2 <= 8'h00;
      p_last       <= 1'b0;
      char_valid   <= 1'b0;
      stream_done  <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr       <= rd_ptr + (DEPTH_LOG2+1)'(1);
        input_char   <= head[7:0];
        input_char_2 <= head[15:8];
        p_last       <= head[16];
      end
      case (state)
        S_EMPTY: begin
          if (pop) begin
            state      <= S_FULL;
            char_valid <= 1'b1;
          end
        end
        S_FULL: begin
          if (input_char_flag) begin
            if (p_last) begin
              stream_done <= 1'b1;
              state       <= S_EMPTY;
              char_valid  <= 1'b0;
            end else if (!pop) begin
              state      <= S_EMPTY;
              char_valid <= 1'b0;
            end
          end
        end
        default: begin
          state      <= S_EMPTY;
          char_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] x);
    return (x == '1) ? x : x + STALL_W'(1);
  endfunction

  // Count flag pulses that find nothing to consume or nothing to follow.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (input_char_flag &&
                 (!char_valid || (empty && !p_last))) begin
      stall_count <= sat_inc(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_char_pair_feeder.sv
// Randomized bench for char_pair_feeder with a queue-based reference model.
module tb_char_pair_feeder;

  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic [7:0]  in_char_2;
  logic        in_last;
  logic        input_char_flag;
  logic [7:0]  input_char;
  logic [7:0]  input_char_2;
  logic        char_valid;
  logic        stream_done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  char_pair_feeder #(.DEPTH_LOG2(6), .STALL_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_char         (in_char),
    .in_char_2       (in_char_2),
    .in_last         (in_last),
    .input_char_flag (input_char_flag),
    .input_char      (input_char),
    .input_char_2    (input_char_2),
    .char_valid      (char_valid),
    .stream_done     (stream_done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: buffered pairs plus the presented pair.
  logic [16:0] mq[$];
  bit          m_cv;
  bit          m_last;
  bit          m_done;
  bit          m_lacc;
  logic [7:0]  m_c;
  logic [7:0]  m_c2;
  int unsigned m_stall;

  int passed;
  int total;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Apply one cycle of inputs, advance the model, then compare on the falling edge.
  task automatic step(input bit rst, input bit v, input logic [7:0] a,
                      input logic [7:0] b, input bit l, input bit f);
    bit acc;
    reset           = rst;
    in_valid        = v;
    in_char         = a;
    in_char_2       = b;
    in_last         = l;
    input_char_flag = f;
    if (rst) begin
      mq.delete();
      m_cv = 0; m_last = 0; m_done = 0; m_lacc = 0;
      m_c = 8'h00; m_c2 = 8'h00; m_stall = 0;
    end else begin
      acc = v && (mq.size() < DEPTH) && !m_lacc;
      if (f && (!m_cv || (mq.size() == 0 && !m_last)))
        if (m_stall < 16'hFFFF) m_stall++;
      if (!m_cv) begin
        if (mq.size() > 0 && !m_done) begin
          {m_last, m_c2, m_c} = mq.pop_front();
          m_cv = 1;
        end
      end else if (f) begin
        if (m_last) begin
          m_done = 1;
          m_cv   = 0;
        end else if (mq.size() > 0) begin
          {m_last, m_c2, m_c} = mq.pop_front();
        end else begin
          m_cv = 0;
        end
      end
      if (acc) begin
        mq.push_back({l, b, a});
        if (l) m_lacc = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("in_ready", in_ready, (mq.size() < DEPTH) ? 1 : 0);
    chk("char_valid", char_valid, m_cv);
    chk("input_char", input_char, m_c);
    chk("input_char_2", input_char_2, m_c2);
    chk("stream_done", stream_done, m_done);
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_count", stall_count, m_stall);
`endif
  endtask

  initial begin
    int sent;
    int cyc;
    bit v;
    passed = 0;
    total  = 0;
    reset = 1; in_valid = 0; in_char = 0; in_char_2 = 0; in_last = 0; input_char_flag = 0;

    // Reset held with a valid host request: nothing may be accepted.
    for (int i = 0; i < 3; i++) step(1, 1, 8'hAA, 8'hBB, 0, 0);

    // Single pair latency.
    step(0, 1, 8'h61, 8'h62, 0, 0);
    step(0, 0, 8'h00, 8'h00, 0, 0);
    step(0, 0, 8'h00, 8'h00, 0, 0);
    step(0, 0, 8'h00, 8'h00, 0, 1);
    step(0, 0, 8'h00, 8'h00, 0, 0);

    // Fill past capacity, then drain back-to-back.
    for (int i = 0; i < 68; i++) step(0, 1, 8'(i), 8'(i), 0, 0);
    for (int i = 0; i < 70; i++) step(0, 0, 8'h00, 8'h00, 0, 1);

    // Random traffic across several pointer wraps.
    sent = 0;
    cyc  = 0;
    while (sent < 200 && cyc < 4000) begin
      v = ($urandom_range(0, 3) != 0);
      if (v && mq.size() < DEPTH) sent++;
      step(0, v, 8'($urandom), 8'($urandom), 0, ($urandom_range(0, 2) != 0));
      cyc++;
    end
    chk("random_sent", sent, 200);
    for (int i = 0; i < 80; i++) step(0, 0, 8'h00, 8'h00, 0, 1);

    // End of stream: third pair carries the last marker.
    step(1, 0, 8'h00, 8'h00, 0, 0);
    step(0, 1, 8'h11, 8'h21, 0, 0);
    step(0, 1, 8'h12, 8'h22, 0, 0);
    step(0, 1, 8'h13, 8'h23, 1, 0);
    step(0, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h55, 8'h66, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 8'h00, 0, 1);

    // Starvation, then reset in the middle of traffic.
    step(1, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom), 8'($urandom), 0, 0);
    step(0, 0, 8'h00, 8'h00, 0, 1);
    step(1, 1, 8'h77, 8'h78, 0, 1);
    step(0, 0, 8'h00, 8'h00, 0, 0);
    step(0, 0, 8'h00, 8'h00, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
